// File: rtl/multicycle_seq.sv
// ---------------------------------------------------------------------------
// multicycle_seq
//
// Control sequencer for a multi-cycle RISC-V style core. It steps through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. Illegal opcodes,
// ecall/ebreak and memory timeouts go to a one-cycle TRAP visit.
//
// Handshake: mem_req is a level request. It is held high in FETCH and MEM
// until mem_ready is sampled high on a rising edge; that cycle completes the
// access. If mem_ready stays low for TIMEOUT+1 consecutive cycles, the
// access is abandoned and the sequencer traps. mem_ready is ignored in all
// other states.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   op_code[6:0] opcode field, valid from DECODE onward
//   f3[2:0]      funct3 field
//   flag         branch condition from the ALU, sampled in EXEC
//   mem_ready    memory completion strobe
//   state[2:0]   current state (FETCH=0 .. TRAP=5), also the debug view
//   mem_req      memory request
//   mem_we       write qualifier for mem_req
//   ir_w         instruction-register load strobe
//   pc_w         PC load strobe
//   pc_s[1:0]    next-PC select (0 pc+4, 1 pc+imm, 2 rs1+imm, 3 trap vector)
//   reg_w        register-file write strobe
//   csr_w        CSR write strobe
//   trap         one-cycle trap pulse
//   timeout_err  sticky: a memory access timed out since reset
// ---------------------------------------------------------------------------
module multicycle_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic [2:0] f3,
    input  logic       flag,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_w,
    output logic       pc_w,
    output logic [1:0] pc_s,
    output logic       reg_w,
    output logic       csr_w,
    output logic       trap,
    output logic       timeout_err
);

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_I      = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_JAL    = 4'd5,
        C_JALR   = 4'd6,
        C_LUI    = 4'd7,
        C_AUIPC  = 4'd8,
        C_SYSTEM = 4'd9
    } cls_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cls_t       cls_q, cls_d;
    logic [2:0] f3_q, f3_d;
    logic       terr_q, terr_d;

    logic       dec_legal;
    cls_t       dec_cls;
    logic       wait_expired;

    // Opcode classification, used only in DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        case (op_code)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1110011: dec_cls = C_SYSTEM;
            default:    dec_legal = 1'b0;
        endcase
    end

    // A ready arriving on the expiring cycle still wins (no trap).
    assign wait_expired = (cnt_q == TMO) && !mem_ready;

    // Next-state logic. The wait counter is zero in every state other than
    // FETCH/MEM, which clears it on each entry into those states.
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        cls_d   = cls_q;
        f3_d    = f3_q;
        terr_d  = terr_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    terr_d  = 1'b1;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DECODE: begin
                f3_d = f3;
                if (!dec_legal) begin
                    state_d = S_TRAP;
                end else begin
                    cls_d = dec_cls;
                    if (dec_cls == C_SYSTEM && f3 == 3'd0) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_FETCH;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    terr_d  = 1'b1;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
            cls_q   <= C_R;
            f3_q    <= 3'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            f3_q    <= f3_d;
            terr_q  <= terr_d;
        end
    end

    assign state = state_q;

    // Outputs decode from registered state plus flag/mem_ready. rst gates
    // them so a reset in the middle of an access drops the request at once.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_w        = 1'b0;
        pc_w        = 1'b0;
        pc_s        = 2'd0;
        reg_w       = 1'b0;
        csr_w       = 1'b0;
        trap        = 1'b0;
        timeout_err = 1'b0;
        if (!rst) begin
            timeout_err = terr_q;
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_w    = mem_ready;
                end
                S_EXEC: begin
                    if (cls_q == C_BRANCH) begin
                        pc_w = 1'b1;
                        pc_s = flag ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls_q == C_STORE);
                    pc_w    = mem_ready && (cls_q == C_STORE);
                end
                S_WB: begin
                    reg_w = 1'b1;
                    pc_w  = 1'b1;
                    case (cls_q)
                        C_JAL:   pc_s = 2'd1;
                        C_JALR:  pc_s = 2'd2;
                        default: pc_s = 2'd0;
                    endcase
                    csr_w = (cls_q == C_SYSTEM) && (f3_q != 3'd0);
                end
                S_TRAP: begin
                    trap = 1'b1;
                    pc_w = 1'b1;
                    pc_s = 2'd3;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_multicycle_seq
//
// Instruction-level reference: each planned instruction expands into the
// cycle trace the sequencer must produce (expected output vector per cycle)
// together with the per-cycle stimulus. The driver applies stimulus on the
// falling edge, compares one cycle's outputs, and the rising edge advances.
// ---------------------------------------------------------------------------
module tb_multicycle_seq;

  localparam int TIMEOUT = 15;

  // opcode classes as listed in the instruction-set table
  localparam int K_ILL = -1;
  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_BR  = 4;
  localparam int K_JAL = 5;
  localparam int K_JLR = 6;
  localparam int K_LUI = 7;
  localparam int K_AUI = 8;
  localparam int K_SYS = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic [2:0] f3;
  logic       flag;
  logic       mem_ready;
  logic [2:0] state;
  logic       mem_req, mem_we, ir_w, pc_w, reg_w, csr_w, trap, timeout_err;
  logic [1:0] pc_s;

  typedef struct packed {
    logic       rdy;
    logic       flg;
    logic [6:0] op;
    logic [2:0] fn3;
  } stim_t;

  stim_t       stim_q[$];
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        te_m = 1'b0;
  logic [6:0]  cur_op = 7'd0;
  logic [2:0]  cur_f3 = 3'd0;

  multicycle_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .f3(f3), .flag(flag),
    .mem_ready(mem_ready), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .ir_w(ir_w), .pc_w(pc_w), .pc_s(pc_s), .reg_w(reg_w), .csr_w(csr_w),
    .trap(trap), .timeout_err(timeout_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  wire [12:0] got_vec = {state, mem_req, mem_we, ir_w, pc_w, pc_s,
                         reg_w, csr_w, trap, timeout_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JLR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUI;
      7'b1110011: return K_SYS;
      default:    return K_ILL;
    endcase
  endfunction

  // one cycle of expected behaviour plus the stimulus applied in it
  task automatic push(input logic [2:0] st, input logic req, input logic we,
                      input logic irw, input logic pcw, input logic [1:0] pcs,
                      input logic regw, input logic csrw, input logic trp,
                      input logic rdy, input logic flg);
    stim_t s;
    s.rdy = rdy; s.flg = flg; s.op = cur_op; s.fn3 = cur_f3;
    stim_q.push_back(s);
    exp_q.push_back({st, req, we, irw, pcw, pcs, regw, csrw, trp, te_m});
  endtask

  task automatic push_trap();
    push(3'd5, 0, 0, 0, 1, 2'd3, 0, 0, 1, rb(), rb());
  endtask

  // waiting part of a FETCH/MEM access; a delay beyond TIMEOUT times out
  // after TIMEOUT+1 unready cycles and the trap visit follows
  task automatic access(input logic [2:0] st, input logic we, input int delay, output bit ok);
    int waits;
    waits = (delay > TIMEOUT) ? TIMEOUT + 1 : delay;
    for (int k = 0; k < waits; k++) push(st, 1, we, 0, 0, 2'd0, 0, 0, 0, 1'b0, rb());
    ok = (delay <= TIMEOUT);
    if (!ok) begin
      te_m = 1'b1;
      push_trap();
    end
  endtask

  task automatic plan_instr(input logic [6:0] op, input logic [2:0] fn3, input logic flg,
                            input int fd, input int md);
    int c;
    bit ok;
    logic [1:0] pcs;
    c = cls_of(op);
    cur_op = op;
    cur_f3 = fn3;
    access(3'd0, 1'b0, fd, ok);
    if (!ok) return;
    push(3'd0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 1'b1, rb());
    push(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, rb(), rb());
    if (c == K_ILL || (c == K_SYS && fn3 == 3'd0)) begin
      push_trap();
      return;
    end
    if (c == K_BR) begin
      push(3'd2, 0, 0, 0, 1, {1'b0, flg}, 0, 0, 0, rb(), flg);
      return;
    end
    push(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, rb(), rb());
    if (c == K_LD || c == K_ST) begin
      access(3'd3, c == K_ST, md, ok);
      if (!ok) return;
      if (c == K_ST) begin
        push(3'd3, 1, 1, 0, 1, 2'd0, 0, 0, 0, 1'b1, rb());
        return;
      end
      push(3'd3, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1'b1, rb());
    end
    pcs = (c == K_JAL) ? 2'd1 : (c == K_JLR) ? 2'd2 : 2'd0;
    push(3'd4, 0, 0, 0, 1, pcs, 1, (c == K_SYS) && (fn3 != 3'd0), 0, rb(), rb());
  endtask

  // driver + scoreboard: pop one cycle's stimulus and expectation
  task automatic run_cycles(input int n);
    stim_t s;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      @(negedge clk);
      s = stim_q.pop_front();
      mem_ready = s.rdy;
      flag      = s.flg;
      op_code   = s.op;
      f3        = s.fn3;
      #1;
      check($sformatf("cyc%0d", cyc), 32'(got_vec), 32'(exp_q.pop_front()));
      cyc++;
    end
  endtask

  task automatic run_all();
    run_cycles(exp_q.size());
  endtask

  // release reset on a falling edge; one unready FETCH cycle then elapses
  task automatic release_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_release", 32'({state, mem_req, mem_we}), 32'({3'd0, 1'b1, 1'b0}));
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] tbl [10];
    tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    if ($urandom_range(0, 9) == 0) return 7'($urandom());
    return tbl[$urandom_range(0, 9)];
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(0, 15) == 0) return $urandom_range(14, 17);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1'b1;
    op_code = 7'd0; f3 = 3'd0; flag = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", 32'(got_vec), 32'd0);
    release_reset();

    // directed instructions
    plan_instr(7'b0110011, 3'd0, 1'b0, 0, 0);    // R-type
    plan_instr(7'b1100011, 3'd0, 1'b1, 1, 0);    // taken branch
    plan_instr(7'b1100011, 3'd1, 1'b0, 0, 0);    // not-taken branch
    plan_instr(7'b0000011, 3'd2, 1'b0, 0, 3);    // load, ready late
    plan_instr(7'b0100011, 3'd2, 1'b0, 2, 1);    // store
    plan_instr(7'b1111111, 3'd0, 1'b0, 0, 0);    // illegal
    plan_instr(7'b1110011, 3'd0, 1'b0, 0, 0);    // ecall
    plan_instr(7'b1110011, 3'd1, 1'b0, 0, 0);    // csrrw
    plan_instr(7'b1101111, 3'd0, 1'b0, 0, 0);    // jal
    plan_instr(7'b1100111, 3'd0, 1'b0, 0, 0);    // jalr
    plan_instr(7'b0010011, 3'd0, 1'b0, 15, 0);   // ready on 16th fetch cycle
    plan_instr(7'b0010011, 3'd0, 1'b0, 16, 0);   // fetch timeout
    plan_instr(7'b0110011, 3'd0, 1'b0, 0, 0);
    plan_instr(7'b0000011, 3'd0, 1'b0, 0, 15);   // mem ready at the limit
    plan_instr(7'b0100011, 3'd0, 1'b0, 0, 20);   // mem timeout
    plan_instr(7'b0110111, 3'd0, 1'b0, 0, 0);
    run_all();

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      plan_instr(rand_op(), 3'($urandom()), rb(), rand_delay(), rand_delay());
    end
    run_all();

    // reset while a store waits in MEM
    plan_instr(7'b0100011, 3'd0, 1'b0, 0, 20);
    run_cycles(5);
    stim_q.delete();
    exp_q.delete();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("store_wait", 32'({state, mem_req, mem_we}), 32'({3'd3, 1'b1, 1'b1}));
    rst = 1'b1;
    #1;
    check("rst_in_mem", 32'(got_vec), 32'd0);
    te_m = 1'b0;
    release_reset();
    plan_instr(7'b0110011, 3'd0, 1'b0, 0, 0);
    plan_instr(7'b0000011, 3'd0, 1'b0, 1, 2);
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
